// File: rtl/adc_rx_pkg.sv
// adc_rx_pkg: shared definitions for the audio codec ADC capture path.
// Contents:
//   rx_state_e   - slot-capture FSM states (IDLE, SKIP, SHIFT, HOLD)
//   CH_LEFT/RIGHT- ADCLRCK level that identifies each channel slot
//   DEF_SAMPLE_W - default captured bits per channel
package adc_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SKIP  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } rx_state_e;

    localparam logic CH_LEFT  = 1'b1;
    localparam logic CH_RIGHT = 1'b0;

    localparam int DEF_SAMPLE_W = 16;

endpackage

// File: rtl/adc_rx_sync_edge.sv
// sync_edge: SYNC_STAGES-deep synchronizer for one codec pin, followed by a
// registered level/rise/fall stage. All three outputs come from the same
// register stage, so instances of equal depth stay cycle-aligned.
// Ports:
//   clk_i   - system clock
//   rst_n_i - asynchronous active-low reset
//   d_i     - asynchronous pin input
//   q_o     - synchronized level
//   rise_o  - one-cycle pulse on a 0->1 transition of the synchronized level
//   fall_o  - one-cycle pulse on a 1->0 transition of the synchronized level
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   level_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   sync_lvl;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q  <= sync_lvl;
            level_q <= sync_lvl;
            rise_q  <= sync_lvl & ~prev_q;
            fall_q  <= ~sync_lvl & prev_q;
        end
    end

    assign q_o    = level_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/adc_rx.sv
// adc_rx: audio codec ADC capture. Oversamples AUD_BCLK/AUD_ADCLRCK/AUD_ADCDAT
// in the clk_50 domain, deserializes MSB-first SAMPLE_W-bit words per slot
// (left-justified or I2S framing), pairs left+right and hands the pair to a
// consumer over a valid/ready handshake.
// Ports:
//   clk_50       - system clock (>= 4x BCLK)
//   ar           - asynchronous active-low reset
//   AUD_BCLK     - codec bit clock, sampled as data
//   AUD_ADCLRCK  - codec ADC frame clock, 1 = left slot, 0 = right slot
//   AUD_ADCDAT   - codec ADC serial data
//   enable       - capture enable
//   rx_ready     - consumer accepts the pair
//   rx_valid     - pair available
//   rx_ldata     - left sample
//   rx_rdata     - right sample
//   overrun      - sticky: a pair was dropped while the previous one was pending
//   clr_overrun  - clears overrun (a simultaneous set wins)
//   frame_err    - one-cycle pulse: slot ended before SAMPLE_W bits were captured
module adc_rx
    import adc_rx_pkg::*;
#(
    parameter int SAMPLE_W    = DEF_SAMPLE_W,
    parameter int I2S_DELAY   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk_50,
    input  logic                ar,
    input  logic                AUD_BCLK,
    input  logic                AUD_ADCLRCK,
    input  logic                AUD_ADCDAT,
    input  logic                enable,
    input  logic                rx_ready,
    output logic                rx_valid,
    output logic [SAMPLE_W-1:0] rx_ldata,
    output logic [SAMPLE_W-1:0] rx_rdata,
    output logic                overrun,
    input  logic                clr_overrun,
    output logic                frame_err
);

    localparam int CNT_W = $clog2(SAMPLE_W + 1);

    // Synchronized pins
    logic bclk_level_unused, bclk_rise, bclk_fall_unused;
    logic lrck_s, lrck_rise_unused, lrck_fall_unused;
    logic dat_s, dat_rise_unused, dat_fall_unused;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
        .clk_i   (clk_50),
        .rst_n_i (ar),
        .d_i     (AUD_BCLK),
        .q_o     (bclk_level_unused),
        .rise_o  (bclk_rise),
        .fall_o  (bclk_fall_unused)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrck (
        .clk_i   (clk_50),
        .rst_n_i (ar),
        .d_i     (AUD_ADCLRCK),
        .q_o     (lrck_s),
        .rise_o  (lrck_rise_unused),
        .fall_o  (lrck_fall_unused)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dat (
        .clk_i   (clk_50),
        .rst_n_i (ar),
        .d_i     (AUD_ADCDAT),
        .q_o     (dat_s),
        .rise_o  (dat_rise_unused),
        .fall_o  (dat_fall_unused)
    );

    // Capture state
    rx_state_e           state_q, state_d;
    logic                lrck_q, lrck_d;
    logic                lrck_seen_q, lrck_seen_d;
    logic [SAMPLE_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                chan_q, chan_d;
    logic [SAMPLE_W-1:0] lhold_q, lhold_d;
    logic                left_ok_q, left_ok_d;

    // Published outputs
    logic                valid_q, valid_d;
    logic [SAMPLE_W-1:0] ldata_q, ldata_d;
    logic [SAMPLE_W-1:0] rdata_q, rdata_d;
    logic                overrun_q, overrun_d;
    logic                frame_err_q, frame_err_d;

    logic                boundary;
    logic                commit;
    logic                publish;
    logic [SAMPLE_W-1:0] shifted;

    always_ff @(posedge clk_50 or negedge ar) begin
        if (!ar) begin
            state_q     <= ST_IDLE;
            lrck_q      <= 1'b0;
            lrck_seen_q <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            chan_q      <= CH_RIGHT;
            lhold_q     <= '0;
            left_ok_q   <= 1'b0;
            valid_q     <= 1'b0;
            ldata_q     <= '0;
            rdata_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lrck_q      <= lrck_d;
            lrck_seen_q <= lrck_seen_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            chan_q      <= chan_d;
            lhold_q     <= lhold_d;
            left_ok_q   <= left_ok_d;
            valid_q     <= valid_d;
            ldata_q     <= ldata_d;
            rdata_q     <= rdata_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lrck_d      = lrck_q;
        lrck_seen_d = lrck_seen_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        chan_d      = chan_q;
        lhold_d     = lhold_q;
        left_ok_d   = left_ok_q;
        valid_d     = valid_q;
        ldata_d     = ldata_q;
        rdata_d     = rdata_q;
        overrun_d   = overrun_q & ~clr_overrun;
        frame_err_d = 1'b0;
        commit      = 1'b0;
        publish     = 1'b0;
        shifted     = {shift_q[SAMPLE_W-2:0], dat_s};

        // The very first BCLK rise after reset only loads the LRCK reference,
        // so the reset value of lrck_q can never fake a slot boundary.
        boundary = bclk_rise & lrck_seen_q & (lrck_s != lrck_q);

        if (bclk_rise) begin
            lrck_d      = lrck_s;
            lrck_seen_d = 1'b1;
        end

        if (!enable) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            left_ok_d = 1'b0;
        end else if (boundary) begin
            if (state_q == ST_SHIFT || state_q == ST_SKIP) begin
                frame_err_d = 1'b1;
            end
            chan_d    = lrck_s;
            bit_cnt_d = '0;
            if (I2S_DELAY == 0) begin
                // Left-justified: the boundary bit itself is the MSB.
                shift_d   = shifted;
                bit_cnt_d = CNT_W'(1);
                state_d   = ST_SHIFT;
            end else begin
                state_d = ST_SKIP;
            end
        end else if (bclk_rise) begin
            case (state_q)
                ST_SKIP: begin
                    shift_d   = shifted;
                    bit_cnt_d = CNT_W'(1);
                    state_d   = ST_SHIFT;
                end
                ST_SHIFT: begin
                    shift_d   = shifted;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(SAMPLE_W - 1)) begin
                        commit  = 1'b1;
                        state_d = ST_HOLD;
                    end
                end
                default: ;
            endcase
        end

        // A right word is only paired with a left word captured earlier in
        // the same frame; an orphan right word is silently dropped.
        if (commit) begin
            if (chan_q == CH_LEFT) begin
                lhold_d   = shifted;
                left_ok_d = 1'b1;
            end else if (left_ok_q) begin
                publish   = 1'b1;
                left_ok_d = 1'b0;
            end
        end

        if (publish) begin
            if (!valid_q || rx_ready) begin
                valid_d = 1'b1;
                ldata_d = lhold_q;
                rdata_d = shifted;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    assign rx_valid  = valid_q;
    assign rx_ldata  = ldata_q;
    assign rx_rdata  = rdata_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_adc_rx.sv
// tb_adc_rx: bench for adc_rx. Two instances share the codec pins: one
// left-justified (dut0) and one I2S (dut1, always ready). A table of frames
// with precomputed pairs, hand-written corner sequences, then randomized
// frames checked against a slot-level reference model.
module tb_adc_rx;

    localparam int W = 16;

    logic clk_50 = 1'b0;
    logic ar     = 1'b0;
    logic bclk   = 1'b0;
    logic lrck   = 1'b0;
    logic dat    = 1'b0;
    logic en     = 1'b0;
    logic rdy0   = 1'b0;
    logic clr    = 1'b0;

    logic         v0, ov0, fe0, v1, ov1, fe1;
    logic [W-1:0] l0, r0, l1, r1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_50 = ~clk_50;

    adc_rx #(.SAMPLE_W(W), .I2S_DELAY(0), .SYNC_STAGES(2)) dut0 (
        .clk_50      (clk_50),
        .ar          (ar),
        .AUD_BCLK    (bclk),
        .AUD_ADCLRCK (lrck),
        .AUD_ADCDAT  (dat),
        .enable      (en),
        .rx_ready    (rdy0),
        .rx_valid    (v0),
        .rx_ldata    (l0),
        .rx_rdata    (r0),
        .overrun     (ov0),
        .clr_overrun (clr),
        .frame_err   (fe0)
    );

    adc_rx #(.SAMPLE_W(W), .I2S_DELAY(1), .SYNC_STAGES(2)) dut1 (
        .clk_50      (clk_50),
        .ar          (ar),
        .AUD_BCLK    (bclk),
        .AUD_ADCLRCK (lrck),
        .AUD_ADCDAT  (dat),
        .enable      (en),
        .rx_ready    (1'b1),
        .rx_valid    (v1),
        .rx_ldata    (l1),
        .rx_rdata    (r1),
        .overrun     (ov1),
        .clr_overrun (1'b0),
        .frame_err   (fe1)
    );

    // Accepted pairs and frame_err pulses, sampled away from the active edge
    logic [2*W-1:0] acc0[$];
    logic [2*W-1:0] acc1[$];
    int fe_cnt0 = 0;
    int fe_cnt1 = 0;

    always @(negedge clk_50) begin
        if (v0 && rdy0) acc0.push_back({l0, r0});
        if (v1) acc1.push_back({l1, r1});
        if (fe0) fe_cnt0++;
        if (fe1) fe_cnt1++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_pair(input string name, input int which, input logic [31:0] exp);
        logic [31:0] got;
        if ((which == 0 && acc0.size() == 0) || (which == 1 && acc1.size() == 0)) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no pair accepted, expected %h", name, exp);
        end else begin
            got = (which == 0) ? acc0.pop_front() : acc1.pop_front();
            check(name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_50);
        #1;
    endtask

    // One BCLK period: pins change while BCLK is low, 8 clk_50 per BCLK
    task automatic bclk_cycle(input logic lr, input logic d);
        bclk = 1'b0;
        lrck = lr;
        dat  = d;
        tick(4);
        bclk = 1'b1;
        tick(4);
    endtask

    // Bit i of a slot carrying word delayed by sd BCLKs, zero outside the word
    function automatic logic slot_bit(input logic [W-1:0] word, input int sd, input int i);
        int j;
        j = i - sd;
        if (j >= 0 && j < W) return word[W-1-j];
        return 1'b0;
    endfunction

    // Reference: a receiver with delay d keeps the W slot bits starting d
    // BCLKs after the boundary.
    function automatic logic [W-1:0] captured(input logic [W-1:0] word, input int sd, input int d);
        logic [W-1:0] res;
        for (int k = 0; k < W; k++) res[W-1-k] = slot_bit(word, sd, d + k);
        return res;
    endfunction

    task automatic send_slot(input logic lr, input logic [W-1:0] word, input int sd,
                             input int first, input int last);
        for (int i = first; i < last; i++) bclk_cycle(lr, slot_bit(word, sd, i));
    endtask

    task automatic send_frame(input logic [W-1:0] lw, input logic [W-1:0] rw,
                              input int sd, input int n);
        send_slot(1'b1, lw, sd, 0, n);
        send_slot(1'b0, rw, sd, 0, n);
        tick(12);
    endtask

    typedef struct {
        logic [W-1:0]   lw;
        logic [W-1:0]   rw;
        int             sd;
        int             n;
        logic [2*W-1:0] e0;
        logic [2*W-1:0] e1;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [2*W-1:0] exp0[$];
        logic [2*W-1:0] exp1[$];
        int fe_base0, fe_base1;

        tbl[0] = '{16'hA5C3, 16'h1234, 0, 32, 32'hA5C3_1234, 32'h4B86_2468};
        tbl[1] = '{16'hA5C3, 16'h1234, 1, 32, 32'h52E1_091A, 32'hA5C3_1234};
        tbl[2] = '{16'hFFFF, 16'h0000, 0, 17, 32'hFFFF_0000, 32'hFFFE_0000};
        tbl[3] = '{16'h8001, 16'h7FFE, 0, 20, 32'h8001_7FFE, 32'h0002_FFFC};
        tbl[4] = '{16'h0F0F, 16'hF0F0, 1, 17, 32'h0787_7878, 32'h0F0F_F0F0};

        // Reset state
        tick(3);
        check("reset_valid", 32'(v0), 32'd0);
        check("reset_ldata", 32'(l0), 32'd0);
        check("reset_rdata", 32'(r0), 32'd0);
        check("reset_overrun", 32'(ov0), 32'd0);
        check("reset_frame_err", 32'(fe0), 32'd0);

        ar   = 1'b1;
        en   = 1'b1;
        rdy0 = 1'b1;
        tick(2);
        for (int i = 0; i < 4; i++) bclk_cycle(1'b0, 1'b0);

        // Table-driven frames
        for (int t = 0; t < 5; t++) begin
            send_frame(tbl[t].lw, tbl[t].rw, tbl[t].sd, tbl[t].n);
            check_pair($sformatf("tbl%0d_lj", t), 0, tbl[t].e0);
            check_pair($sformatf("tbl%0d_i2s", t), 1, tbl[t].e1);
        end
        check("tbl_single_pulse", 32'(acc0.size()), 32'd0);
        check("tbl_frame_err", 32'(fe_cnt0 + fe_cnt1), 32'd0);
        check("tbl_overrun", 32'(ov0), 32'd0);

        // Overrun: consumer stalls over two frames
        rdy0 = 1'b0;
        send_frame(16'hA5C3, 16'h1234, 0, 32);
        send_frame(16'h0F0F, 16'hF0F0, 0, 32);
        check("ovr_valid", 32'(v0), 32'd1);
        check("ovr_hold_pair", {l0, r0}, 32'hA5C3_1234);
        check("ovr_set", 32'(ov0), 32'd1);
        check_pair("ovr_i2s_a", 1, 32'h4B86_2468);
        check_pair("ovr_i2s_b", 1, 32'h1E1E_E1E0);
        rdy0 = 1'b1;
        tick(1);
        check("ovr_valid_drop", 32'(v0), 32'd0);
        check_pair("ovr_accepted", 0, 32'hA5C3_1234);
        check("ovr_sticky", 32'(ov0), 32'd1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("ovr_clear", 32'(ov0), 32'd0);

        // Short left slot
        fe_base0 = fe_cnt0;
        fe_base1 = fe_cnt1;
        send_slot(1'b1, 16'hA5C3, 0, 0, 10);
        send_slot(1'b0, 16'h1234, 0, 0, 32);
        tick(12);
        check("ferr_pulse_lj", 32'(fe_cnt0 - fe_base0), 32'd1);
        check("ferr_pulse_i2s", 32'(fe_cnt1 - fe_base1), 32'd1);
        check("ferr_no_pair", 32'(acc0.size() + acc1.size()), 32'd0);
        send_frame(16'h0F0F, 16'hF0F0, 0, 32);
        check_pair("ferr_recover_lj", 0, 32'h0F0F_F0F0);
        check_pair("ferr_recover_i2s", 1, 32'h1E1E_E1E0);

        // Reset asserted mid-SHIFT with a pending pair and overrun set
        rdy0 = 1'b0;
        send_frame(16'h3C3C, 16'hC3C3, 0, 32);
        send_frame(16'h1111, 16'h2222, 0, 32);
        check("pre_rst_valid", 32'(v0), 32'd1);
        check("pre_rst_overrun", 32'(ov0), 32'd1);
        check_pair("pre_rst_i2s_a", 1, 32'h7878_8786);
        check_pair("pre_rst_i2s_b", 1, 32'h2222_4444);
        send_slot(1'b1, 16'h3C3C, 0, 0, 8);
        ar = 1'b0;
        #2;
        check("arst_valid", 32'(v0), 32'd0);
        check("arst_pair", {l0, r0}, 32'd0);
        check("arst_overrun", 32'(ov0), 32'd0);
        rdy0 = 1'b1;
        send_slot(1'b1, 16'h3C3C, 0, 8, 32);
        send_slot(1'b0, 16'hC3C3, 0, 0, 10);
        ar = 1'b1;
        send_slot(1'b0, 16'hC3C3, 0, 10, 32);
        tick(12);
        check("rst_mid_right_no_pair", 32'(acc0.size() + acc1.size()), 32'd0);
        send_frame(16'h5A5A, 16'h6969, 0, 32);
        check_pair("rst_first_lj", 0, 32'h5A5A_6969);
        check_pair("rst_first_i2s", 1, 32'hB4B4_D2D2);

        // Enable dropped mid-left, restored mid-right
        fe_base0 = fe_cnt0;
        send_slot(1'b1, 16'h7E7E, 0, 0, 8);
        en = 1'b0;
        tick(2);
        check("dis_keep_pair", {l0, r0}, 32'h5A5A_6969);
        send_slot(1'b1, 16'h7E7E, 0, 8, 32);
        send_slot(1'b0, 16'hE7E7, 0, 0, 10);
        en = 1'b1;
        send_slot(1'b0, 16'hE7E7, 0, 10, 32);
        tick(12);
        check("dis_no_pair", 32'(acc0.size() + acc1.size()), 32'd0);
        check("dis_no_ferr", 32'(fe_cnt0 - fe_base0), 32'd0);
        send_frame(16'h7E7E, 16'hE7E7, 0, 32);
        check_pair("en_first_lj", 0, 32'h7E7E_E7E7);
        check_pair("en_first_i2s", 1, 32'hFCFC_CFCE);

        // Randomized frames against the slot-level model
        fe_base0 = fe_cnt0;
        fe_base1 = fe_cnt1;
        for (int f = 0; f < 12; f++) begin
            logic [W-1:0] lw, rw;
            int sd, n;
            lw = W'($urandom);
            rw = W'($urandom);
            sd = int'($urandom_range(0, 1));
            n  = int'($urandom_range(17, 24));
            exp0.push_back({captured(lw, sd, 0), captured(rw, sd, 0)});
            exp1.push_back({captured(lw, sd, 1), captured(rw, sd, 1)});
            send_frame(lw, rw, sd, n);
        end
        check("rnd_count_lj", 32'(acc0.size()), 32'(exp0.size()));
        check("rnd_count_i2s", 32'(acc1.size()), 32'(exp1.size()));
        while (exp0.size() > 0) check_pair("rnd_lj", 0, exp0.pop_front());
        while (exp1.size() > 0) check_pair("rnd_i2s", 1, exp1.pop_front());
        check("rnd_frame_err", 32'((fe_cnt0 - fe_base0) + (fe_cnt1 - fe_base1)), 32'd0);
        check("rnd_overrun", 32'(ov0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3ms;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/adc_rx.md
Name: adc_rx

Overview:
- Capture-side counterpart of the codec DAC playback path.
- Deserializes the audio codec ADC serial stream (AUD_ADCDAT framed by AUD_BCLK / AUD_ADCLRCK) into stereo SAMPLE_W-bit words.
- Codec pins are oversampled in the clk_50 domain. Complete left+right pairs go out on a valid/ready handshake to downstream blocks (wavetable loader, effects).

Parameters:
- SAMPLE_W, 16: captured bits per channel, MSB first; later slot bits are ignored.
- I2S_DELAY, 0: 0 = left-justified (MSB on first BCLK rise after an LRCK change); 1 = I2S (MSB one BCLK later).
- SYNC_STAGES, 2: synchronizer depth for BCLK, ADCLRCK and ADCDAT (minimum 2).

Ports:
- clk_50  in  1  system clock, sole clock; must be ≥4× BCLK.
- ar  in  1  asynchronous active-low reset.
- AUD_BCLK  in  1  codec bit clock, sampled as data.
- AUD_ADCLRCK  in  1  codec ADC frame clock; 1 = left, 0 = right.
- AUD_ADCDAT  in  1  codec ADC serial data.
- enable  in  1  capture enable.
- rx_ready  in  1  consumer accepts the pair.
- rx_valid  out  1  pair available.
- rx_ldata  out  SAMPLE_W  left sample.
- rx_rdata  out  SAMPLE_W  right sample.
- overrun  out  1  sticky: pair dropped while rx_valid & ~rx_ready.
- clr_overrun  in  1  clears overrun.
- frame_err  out  1  one-cycle pulse: slot ended before SAMPLE_W bits were captured.

Behaviour:
- Reset (ar low, async): all outputs 0, FSM = IDLE, shift register, bit counter and left-hold register cleared, left_ok = 0.
- Synchronization:
  - All three pins pass through SYNC_STAGES flops (equal depth keeps them aligned).
  - bclk_rise = sync_bclk & ~bclk_d.
  - LRCK is registered only on bclk_rise events.
  - A boundary is an LRCK change seen at a bclk_rise; new channel = new LRCK value.
- FSM states: IDLE, SKIP, SHIFT, HOLD.
  - IDLE: wait for the first boundary, so capture never starts mid-slot. On boundary: set bit_cnt = 0. If I2S_DELAY = 0, go to SHIFT and capture this same event's data bit as the MSB. If I2S_DELAY = 1, go to SKIP.
  - SKIP: next bclk_rise → SHIFT, capturing that bit as the MSB.
  - SHIFT: each bclk_rise does shift = {shift[SAMPLE_W-2:0], dat} and bit_cnt++. After bit SAMPLE_W-1, commit the word to the channel and go to HOLD.
  - HOLD: ignore data until a boundary, then enter as from IDLE.
  - Boundary while in SHIFT or SKIP: pulse frame_err, discard the partial word, restart on the new channel.
- Commit rules:
  - Left commit: load the left-hold register, set left_ok = 1.
  - Right commit with left_ok = 1: publish the pair, clear left_ok.
  - Right commit with left_ok = 0 (first frame after reset/enable, or after a frame_err in the left slot): discard.
- Publish:
  - If ~rx_valid, or rx_valid & rx_ready in the same cycle: load rx_ldata/rx_rdata and set rx_valid = 1.
  - Otherwise: drop the new pair, set overrun, leave outputs unchanged.
  - rx_valid & rx_ready with no publish → rx_valid = 0. Data outputs hold their last value.
- clr_overrun clears overrun. A simultaneous set wins.
- enable low: FSM → IDLE, partial word and left_ok discarded, published outputs and handshake unaffected. Re-enable waits for a new boundary.
- Latency: rx_valid rises SYNC_STAGES+3 clk_50 cycles (±1 for sampling phase) after the pin BCLK rise carrying the right-channel LSB.
- BCLK-per-slot count is unconstrained as long as it is ≥ SAMPLE_W + I2S_DELAY.

Decomposition:
- Package adc_rx_pkg:
  - FSM state encoding (IDLE/SKIP/SHIFT/HOLD).
  - Channel constants CH_LEFT = 1'b1, CH_RIGHT = 1'b0.
  - Default SAMPLE_W.
- Sub-module sync_edge (SYNC_STAGES-deep synchronizer plus rise/fall detect), instantiated for BCLK, ADCLRCK and ADCDAT. Fall/rise outputs on the LRCK and DAT instances are unused.

Test Plan:
- LJ, 64 BCLK/frame, left = 16'hA5C3, right = 16'h1234, rx_ready = 1 → exactly one rx_valid pulse per frame with ldata = A5C3, rdata = 1234; frame_err and overrun stay 0.
- I2S_DELAY = 1, stream MSB-aligned one BCLK late → A5C3/1234. Same module fed a left-justified stream → ldata = 16'h4B86 (one-bit shift, zero fill).
- rx_ready = 0 over two frames (pairs A5C3/1234 then 0F0F/F0F0) → outputs hold A5C3/1234 and overrun = 1. Then rx_ready = 1 → rx_valid drops; clr_overrun → overrun = 0.
- LRCK toggles after 10 BCLKs in the left slot → one frame_err pulse, no rx_valid that frame; next full frame publishes normally.
- Release reset mid right slot → no publish until a complete left then right has been captured.
- Assert ar during SHIFT → all outputs 0 immediately. After release, the first publish requires a fresh boundary; enable low mid-slot behaves the same but keeps outputs.
